spi_flash_reader: RTL and testbench

SPI_FLASH_READER -- requirements
Module: spi_flash_reader

---
 rtl/spi_flash_reader_pkg.sv | 21 ++
 rtl/spi_flash_reader.sv | 162 ++++++++++++++++
 tb/tb_spi_flash_reader.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_reader_pkg.sv
// Shared definitions for the SPI flash read sequencer: state encoding,
// default opcode and request length decoding.
package spi_flash_reader_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CMD   = 3'd1;
  localparam logic [2:0] ST_A2    = 3'd2;
  localparam logic [2:0] ST_A1    = 3'd3;
  localparam logic [2:0] ST_A0    = 3'd4;
  localparam logic [2:0] ST_DATA  = 3'd5;
  localparam logic [2:0] ST_DRAIN = 3'd6;
  localparam logic [2:0] ST_GAP   = 3'd7;

  localparam logic [7:0] CMD_READ_DFLT = 8'h03;

  // A zero length field encodes a full 256-byte read.
  function automatic logic [8:0] len_to_count(input logic [7:0] len);
    return (len == 8'd0) ? 9'd256 : {1'b0, len};
  endfunction

endpackage

// File: rtl/spi_flash_reader.sv
// Sequences a flash READ (opcode, 24-bit address, N data bytes) over an
// external SPI byte engine and streams received bytes out with backpressure.
module spi_flash_reader
  import spi_flash_reader_pkg::*;
#(
  parameter logic [7:0]  CMD_READ = CMD_READ_DFLT,
  parameter int unsigned CS_GAP   = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [23:0] req_addr_i,
  input  logic [7:0]  req_len_i,
  output logic        spi_start_o,
  output logic [7:0]  spi_tx_o,
  input  logic        spi_done_i,
  input  logic [7:0]  spi_rx_i,
  output logic        cs_b_o,
  output logic        rd_valid_o,
  input  logic        rd_ready_i,
  output logic [7:0]  rd_data_o,
  output logic        rd_last_o,
  input  logic        abort_i,
  output logic        busy_o
);

  logic [2:0]  state_q, state_d;
  logic [23:0] addr_q, addr_d;
  logic [8:0]  rem_q, rem_d;
  logic [3:0]  gap_q, gap_d;
  logic        start_q, start_d;
  logic [7:0]  tx_q, tx_d;
  logic        inflight_q, inflight_d;
  logic        abort_q, abort_d;
  logic        cs_b_q, cs_b_d;
  logic        rd_valid_q, rd_valid_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        rd_last_q, rd_last_d;
  logic        handoff;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    gap_d      = gap_q;
    start_d    = 1'b0;
    tx_d       = tx_q;
    inflight_d = inflight_q;
    abort_d    = abort_q;
    cs_b_d     = cs_b_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    rd_last_d  = rd_last_q;
    handoff    = rd_valid_q & rd_ready_i;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          addr_d     = req_addr_i;
          rem_d      = len_to_count(req_len_i);
          state_d    = ST_CMD;
          start_d    = 1'b1;
          tx_d       = CMD_READ;
          inflight_d = 1'b1;
          cs_b_d     = 1'b0;
        end
      end
      ST_CMD, ST_A2, ST_A1, ST_A0, ST_DATA: begin
        // Abort lets an in-flight byte finish on the wire, then drops it.
        if (abort_i || abort_q) begin
          rd_valid_d = 1'b0;
          if (!inflight_q || spi_done_i) begin
            state_d    = ST_GAP;
            gap_d      = 4'(CS_GAP - 1);
            cs_b_d     = 1'b1;
            inflight_d = 1'b0;
            abort_d    = 1'b0;
          end else begin
            abort_d = 1'b1;
          end
        end else if (state_q != ST_DATA) begin
          if (spi_done_i) begin
            start_d = 1'b1;
            case (state_q)
              ST_CMD:  begin state_d = ST_A2;   tx_d = addr_q[23:16]; end
              ST_A2:   begin state_d = ST_A1;   tx_d = addr_q[15:8];  end
              ST_A1:   begin state_d = ST_A0;   tx_d = addr_q[7:0];   end
              default: begin state_d = ST_DATA; tx_d = 8'h00;         end
            endcase
          end
        end else if (spi_done_i && inflight_q) begin
          rd_valid_d = 1'b1;
          rd_data_d  = spi_rx_i;
          rd_last_d  = (rem_q == 9'd1);
          inflight_d = 1'b0;
          if (rem_q != 9'd0) rem_d = rem_q - 9'd1;
        end else if (handoff) begin
          // Next byte only launches once the output register has emptied.
          rd_valid_d = 1'b0;
          if (rem_q != 9'd0) begin
            start_d    = 1'b1;
            tx_d       = 8'h00;
            inflight_d = 1'b1;
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        state_d = ST_GAP;
        gap_d   = 4'(CS_GAP - 1);
        cs_b_d  = 1'b1;
      end
      ST_GAP: begin
        if (gap_q == 4'd0) state_d = ST_IDLE;
        else               gap_d   = gap_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      gap_q      <= '0;
      start_q    <= 1'b0;
      tx_q       <= '0;
      inflight_q <= 1'b0;
      abort_q    <= 1'b0;
      cs_b_q     <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      gap_q      <= gap_d;
      start_q    <= start_d;
      tx_q       <= tx_d;
      inflight_q <= inflight_d;
      abort_q    <= abort_d;
      cs_b_q     <= cs_b_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_last_q  <= rd_last_d;
    end
  end

  assign req_ready_o = (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);
  assign spi_start_o = start_q;
  assign spi_tx_o    = tx_q;
  assign cs_b_o      = cs_b_q;
  assign rd_valid_o  = rd_valid_q;
  assign rd_data_o   = rd_data_q;
  assign rd_last_o   = rd_last_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: a flash/byte-engine model answers SPI bytes,
// a scoreboard holds expected TX bytes and read beats per request.
module tb_spi_flash_reader;

  localparam int CS_GAP = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [23:0] req_addr;
  logic [7:0]  req_len;
  logic        spi_start;
  logic [7:0]  spi_tx;
  logic        spi_done;
  logic [7:0]  spi_rx;
  logic        cs_b;
  logic        rd_valid, rd_ready, rd_last;
  logic [7:0]  rd_data;
  logic        abort, busy;

  always #5 clk = ~clk;

  spi_flash_reader #(.CMD_READ(8'h03), .CS_GAP(CS_GAP)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_len_i(req_len),
    .spi_start_o(spi_start), .spi_tx_o(spi_tx),
    .spi_done_i(spi_done), .spi_rx_i(spi_rx),
    .cs_b_o(cs_b),
    .rd_valid_o(rd_valid), .rd_ready_i(rd_ready),
    .rd_data_o(rd_data), .rd_last_o(rd_last),
    .abort_i(abort), .busy_o(busy)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_tx[$];
  logic [8:0] exp_rd[$];

  int start_cnt = 0, beat_cnt = 0, gap_cnt = 0, last_cs_run = 0;
  int unsigned epoch = 0;
  logic rdy_rand = 1'b0, rdy_fixed = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected completion", name);
  endtask

  // Flash contents: a fixed arithmetic pattern of the byte address.
  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    int unsigned s;
    s = int'(a) * 7 + int'(a >> 8) * 3 + int'(a >> 16) + 90;
    return 8'(s);
  endfunction

  task automatic push_exp(input logic [23:0] a, input logic [7:0] l);
    int n;
    n = (l == 8'd0) ? 256 : int'(l);
    exp_tx.push_back(8'h03);
    exp_tx.push_back(a[23:16]);
    exp_tx.push_back(a[15:8]);
    exp_tx.push_back(a[7:0]);
    for (int i = 0; i < n; i++) begin
      exp_tx.push_back(8'h00);
      exp_rd.push_back({(i == n - 1), flash_byte(a + 24'(i))});
    end
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 3000);
    if (n >= 3000) fail_now(name);
  endtask

  task automatic issue(input logic [23:0] a, input logic [7:0] l);
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = a; req_len = l;
    wait_ready("req_accept");
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end
    while ((busy || exp_tx.size() != 0 || exp_rd.size() != 0) && n < 5000);
    if (n >= 5000) fail_now(name);
    chk({name, "_busy"}, busy, 0);
  endtask

  task automatic wait_starts(input int target);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (start_cnt < target && n < 3000);
    if (n >= 3000) fail_now("wait_starts");
  endtask

  // Read-ready driver
  initial begin
    rd_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      rd_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end
  end

  // Byte engine + flash model: decodes the address from the bytes on the wire.
  initial begin : engine
    int idx;
    int unsigned ep;
    logic [23:0] eng_addr;
    logic [7:0]  rx;
    spi_done = 1'b0;
    spi_rx   = 8'h00;
    idx      = 0;
    eng_addr = '0;
    forever begin
      @(negedge clk);
      if (cs_b) idx = 0;
      if (rst_n && spi_start) begin
        chk("cs_low_at_start", cs_b, 0);
        if (exp_tx.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_start: got tx %0h expected no start", spi_tx);
        end else begin
          chk("tx_byte", spi_tx, exp_tx.pop_front());
        end
        case (idx)
          1: eng_addr[23:16] = spi_tx;
          2: eng_addr[15:8]  = spi_tx;
          3: eng_addr[7:0]   = spi_tx;
          default: ;
        endcase
        rx = (idx >= 4) ? flash_byte(eng_addr + 24'(idx - 4)) : 8'($urandom);
        idx++;
        ep = epoch;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        if (ep == epoch && rst_n) begin
          spi_done = 1'b1; spi_rx = rx;
          @(posedge clk); #1;
          spi_done = 1'b0; spi_rx = 8'($urandom);
        end
      end
    end
  end

  // Monitor: pops expected beats, checks hold stability and start discipline.
  initial begin : monitor
    int outstanding, cs_run;
    logic prev_hold;
    logic [8:0] prev_beat, e;
    outstanding = 0; cs_run = 0; prev_hold = 1'b0; prev_beat = '0;
    forever begin
      @(negedge clk);
      if (cs_b) cs_run++;
      else begin
        if (cs_run != 0) last_cs_run = cs_run;
        cs_run = 0;
      end
      if (!rst_n) begin
        outstanding = 0;
        prev_hold   = 1'b0;
      end else begin
        if (busy && cs_b) gap_cnt++;
        if (spi_done && outstanding > 0) outstanding--;
        if (spi_start) begin
          start_cnt++;
          chk("one_byte_in_flight", outstanding, 0);
          outstanding++;
        end
        if (rd_valid) chk("no_start_while_full", spi_start, 0);
        if (prev_hold && rd_valid) chk("hold_stable", {rd_last, rd_data}, prev_beat);
        if (rd_valid && rd_ready) begin
          beat_cnt++;
          if (exp_rd.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat: got %0h expected no beat", rd_data);
          end else begin
            e = exp_rd.pop_front();
            chk("rd_data", rd_data, e[7:0]);
            chk("rd_last", rd_last, e[8]);
          end
        end
        prev_hold = rd_valid && !rd_ready;
        prev_beat = {rd_last, rd_data};
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int s0, b0, g0;
    logic [23:0] a;
    logic [7:0]  l;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0; abort = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_b", cs_b, 1);
    chk("rst_start", spi_start, 0);
    chk("rst_tx", spi_tx, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_last", rd_last, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_req_ready", req_ready, 1);

    // Basic read of 4 bytes at 0x123456
    s0 = start_cnt; b0 = beat_cnt; g0 = gap_cnt;
    push_exp(24'h123456, 8'd4);
    issue(24'h123456, 8'd4);
    wait_idle("basic");
    chk("basic_starts", start_cnt - s0, 8);
    chk("basic_beats", beat_cnt - b0, 4);
    chk("basic_gap", gap_cnt - g0, CS_GAP);

    // Length 0 means 256 bytes
    s0 = start_cnt; b0 = beat_cnt;
    push_exp(24'hFFFF80, 8'd0);
    issue(24'hFFFF80, 8'd0);
    wait_idle("len256");
    chk("len256_beats", beat_cnt - b0, 256);
    chk("len256_starts", start_cnt - s0, 260);

    // Backpressure stall of 10 cycles after first data
    rdy_fixed = 1'b0;
    b0 = beat_cnt;
    push_exp(24'hABCDEF, 8'd3);
    issue(24'hABCDEF, 8'd3);
    begin
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (!rd_valid && n < 200);
      if (n >= 200) fail_now("stall_first_valid");
    end
    s0 = start_cnt;
    repeat (10) @(negedge clk);
    chk("stall_no_start", start_cnt - s0, 0);
    chk("stall_valid_held", rd_valid, 1);
    chk("stall_data", rd_data, flash_byte(24'hABCDEF));
    rdy_fixed = 1'b1;
    wait_idle("stall");
    chk("stall_beats", beat_cnt - b0, 3);

    // Abort during A1: that byte finishes, nothing more follows
    s0 = start_cnt; b0 = beat_cnt; g0 = gap_cnt;
    exp_tx.push_back(8'h03); exp_tx.push_back(8'h44); exp_tx.push_back(8'h55);
    issue(24'h445566, 8'd5);
    wait_starts(s0 + 3);
    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    wait_idle("abort_a1");
    chk("abort_a1_starts", start_cnt - s0, 3);
    chk("abort_a1_beats", beat_cnt - b0, 0);
    chk("abort_a1_gap", gap_cnt - g0, CS_GAP);
    chk("abort_a1_cs", cs_b, 1);

    // Abort coinciding with first data byte done: byte is dropped
    s0 = start_cnt; b0 = beat_cnt;
    exp_tx.push_back(8'h03); exp_tx.push_back(8'h01);
    exp_tx.push_back(8'h02); exp_tx.push_back(8'h03); exp_tx.push_back(8'h00);
    issue(24'h010203, 8'd3);
    begin
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (!(start_cnt - s0 == 5 && spi_done) && n < 500);
      if (n >= 500) fail_now("abort_done_align");
    end
    abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    wait_idle("abort_done");
    chk("abort_done_beats", beat_cnt - b0, 0);
    chk("abort_done_starts", start_cnt - s0, 5);

    // Reset during second data byte
    s0 = start_cnt;
    push_exp(24'h777000, 8'd4);
    issue(24'h777000, 8'd4);
    wait_starts(s0 + 6);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_cs_b", cs_b, 1);
    chk("midrst_rd_valid", rd_valid, 0);
    chk("midrst_start", spi_start, 0);
    chk("midrst_busy", busy, 0);
    epoch++;
    exp_tx.delete();
    exp_rd.delete();
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    s0 = start_cnt; b0 = beat_cnt;
    push_exp(24'h0000F0, 8'd2);
    issue(24'h0000F0, 8'd2);
    wait_idle("post_rst");
    chk("post_rst_beats", beat_cnt - b0, 2);
    chk("post_rst_starts", start_cnt - s0, 6);

    // Back-to-back: second request held valid while the first runs;
    // cs_b is high for the GAP cycles plus the IDLE accept cycle.
    push_exp(24'h200000, 8'd2);
    push_exp(24'h300000, 8'd1);
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 24'h200000; req_len = 8'd2;
    wait_ready("b2b_first");
    @(posedge clk); #1;
    req_addr = 24'h300000; req_len = 8'd1;
    wait_ready("b2b_second");
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_idle("b2b");
    chk("b2b_cs_high", last_cs_run, CS_GAP + 1);

    // Randomized requests with random read backpressure
    rdy_rand = 1'b1;
    for (int t = 0; t < 12; t++) begin
      a = 24'($urandom);
      l = 8'($urandom_range(1, 9));
      b0 = beat_cnt;
      push_exp(a, l);
      issue(a, l);
      wait_idle("rand");
      chk("rand_beats", beat_cnt - b0, int'(l));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    rdy_rand = 1'b0;

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
